// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
//   Serialises a fixed UART command frame as back-to-back 8N1 bytes:
//     0x55, 0xA5, Time[31:24], Time[23:16], Time[15:8], Time[7:0], Ctrl,
//     [checksum,] 0xF0
//   Ctrl, Time and Baud_set are captured when a frame starts and held
//   for the whole frame. Each byte is followed by one extra idle-high
//   cycle, because the frame byte for the next slot is selected in LOAD.
//
// Optional build macro:
//   UART_FRAME_TX_CHECKSUM_EN - inserts an 8-bit additive checksum of the
//   four Time bytes and Ctrl between Ctrl and the 0xF0 tail.
//
// Parameters:
//   CLK_FREQ   - system clock in Hz; bit period = CLK_FREQ / baud.
// Ports:
//   Clk        - system clock
//   Reset_n    - synchronous reset, active HIGH despite its name
//   Baud_set   - 0:9600 1:19200 2:38400 3:57600 4:115200, 5..7 -> 9600
//   Ctrl       - control byte to send
//   Time       - 32-bit time word to send
//   Send_go    - start request (pulse or level), ignored while busy
//   uart_tx    - serial output, idles high
//   Busy       - frame in progress
//   Byte_done  - one-cycle pulse after each byte's stop bit
//   Frame_done - one-cycle pulse, one cycle after the last Byte_done
// ---------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [2:0]  Baud_set,
    input  logic [7:0]  Ctrl,
    input  logic [31:0] Time,
    input  logic        Send_go,
    output logic        uart_tx,
    output logic        Busy,
    output logic        Byte_done,
    output logic        Frame_done
);

    // Wide enough for the slowest (9600 baud) bit period.
    localparam int CW = $clog2(CLK_FREQ / 9600 + 1);

`ifdef UART_FRAME_TX_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [CW-1:0] bit_cycles(input logic [2:0] sel);
        case (sel)
            3'd1:    bit_cycles = CW'(CLK_FREQ / 19200);
            3'd2:    bit_cycles = CW'(CLK_FREQ / 38400);
            3'd3:    bit_cycles = CW'(CLK_FREQ / 57600);
            3'd4:    bit_cycles = CW'(CLK_FREQ / 115200);
            default: bit_cycles = CW'(CLK_FREQ / 9600);
        endcase
    endfunction

`ifdef UART_FRAME_TX_CHECKSUM_EN
    function automatic logic [7:0] checksum(input logic [7:0]  ctrl,
                                            input logic [31:0] tm);
        checksum = tm[31:24] + tm[23:16] + tm[15:8] + tm[7:0] + ctrl;
    endfunction
`endif

    function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                              input logic [7:0]  ctrl,
                                              input logic [31:0] tm);
        case (idx)
            4'd0:    frame_byte = 8'h55;
            4'd1:    frame_byte = 8'hA5;
            4'd2:    frame_byte = tm[31:24];
            4'd3:    frame_byte = tm[23:16];
            4'd4:    frame_byte = tm[15:8];
            4'd5:    frame_byte = tm[7:0];
            4'd6:    frame_byte = ctrl;
`ifdef UART_FRAME_TX_CHECKSUM_EN
            4'd7:    frame_byte = checksum(ctrl, tm);
`endif
            default: frame_byte = 8'hF0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [31:0] time_q, time_d;
    logic [CW-1:0] bit_cyc_q, bit_cyc_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  byte_idx_q, byte_idx_d;
    // {stop, data[7:0], start}; bit 0 is the bit currently on the line.
    logic [9:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        byte_done_q, byte_done_d;
    logic        frame_pend_q, frame_pend_d;
    logic        frame_done_q, frame_done_d;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        time_d       = time_q;
        bit_cyc_d    = bit_cyc_q;
        baud_cnt_d   = baud_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        tx_d         = 1'b1;
        busy_d       = (state_q != IDLE);
        byte_done_d  = 1'b0;
        frame_pend_d = 1'b0;
        // Frame_done trails the DONE state by one extra stage so that it
        // lines up with Busy falling.
        frame_done_d = frame_pend_q;

        case (state_q)
            IDLE: begin
                if (Send_go) begin
                    ctrl_d     = Ctrl;
                    time_d     = Time;
                    bit_cyc_d  = bit_cycles(Baud_set);
                    byte_idx_d = 4'd0;
                    state_d    = LOAD;
                end else begin
                    state_d    = IDLE;
                end
            end
            LOAD: begin
                shift_d     = {1'b1, frame_byte(byte_idx_q, ctrl_q, time_q), 1'b0};
                baud_cnt_d  = {CW{1'b0}};
                bit_cnt_d   = 4'd0;
                // A LOAD with a non-zero index follows a finished byte.
                byte_done_d = (byte_idx_q != 4'd0);
                state_d     = SHIFT;
            end
            SHIFT: begin
                tx_d = shift_q[0];
                if (baud_cnt_q == bit_cyc_q - CW'(1)) begin
                    baud_cnt_d = {CW{1'b0}};
                    shift_d    = {1'b1, shift_q[9:1]};
                    if (bit_cnt_q == 4'd9) begin
                        bit_cnt_d = 4'd0;
                        if (byte_idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            byte_idx_d = byte_idx_q + 4'd1;
                            state_d    = LOAD;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CW'(1);
                end
            end
            DONE: begin
                byte_done_d  = 1'b1;
                frame_pend_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset_n) begin
            state_q      <= IDLE;
            ctrl_q       <= 8'h00;
            time_q       <= 32'h0000_0000;
            bit_cyc_q    <= {CW{1'b0}};
            baud_cnt_q   <= {CW{1'b0}};
            bit_cnt_q    <= 4'd0;
            byte_idx_q   <= 4'd0;
            shift_q      <= 10'h3FF;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            byte_done_q  <= 1'b0;
            frame_pend_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            time_q       <= time_d;
            bit_cyc_q    <= bit_cyc_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            byte_done_q  <= byte_done_d;
            frame_pend_q <= frame_pend_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign uart_tx    = tx_q;
    assign Busy       = busy_q;
    assign Byte_done  = byte_done_q;
    assign Frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_tx
//   Directed bench for uart_frame_tx at CLK_FREQ = 50 MHz.
//   Cycle numbering: n = 0 is the state right after the clock edge that
//   samples Send_go; outputs are sampled 1 ns after each rising edge.
//   Expected frame timing: start bit of byte k at n = 2 + k*(10*B+1),
//   Byte_done of byte k at n = (k+1)*(10*B+1) + 1,
//   Frame_done with Busy low at n = NB*(10*B+1) + 2.
// ---------------------------------------------------------------------------
module tb_uart_frame_tx;

    localparam int B4   = 434;
`ifdef UART_FRAME_TX_CHECKSUM_EN
    localparam int NB   = 9;
`else
    localparam int NB   = 8;
`endif
    localparam int FLEN = NB * (10 * B4 + 1) + 2;
    localparam int TAIL = 500;
    localparam int HLEN = 40000;

    logic        clk_s      = 1'b0;
    logic        reset_s    = 1'b1;
    logic [2:0]  baud_s     = 3'd4;
    logic [7:0]  ctrl_s     = 8'h00;
    logic [31:0] time_s     = 32'h0;
    logic        go_s       = 1'b0;
    logic        tx_s;
    logic        busy_s;
    logic        bd_s;
    logic        fd_s;

    uart_frame_tx #(.CLK_FREQ(50_000_000)) dut (
        .Clk        (clk_s),
        .Reset_n    (reset_s),
        .Baud_set   (baud_s),
        .Ctrl       (ctrl_s),
        .Time       (time_s),
        .Send_go    (go_s),
        .uart_tx    (tx_s),
        .Busy       (busy_s),
        .Byte_done  (bd_s),
        .Frame_done (fd_s)
    );

    always #5 clk_s = ~clk_s;

    typedef struct {
        logic [2:0] baud;        // Baud_set when the frame starts
        logic [2:0] baud_after;  // Baud_set applied right after the start
        int         exp_cyc;     // expected start-bit length in cycles
    } baud_vec_t;

    baud_vec_t   bv [8];
    logic [7:0]  exp_bytes [9];
    logic        tx_h   [HLEN];
    logic        busy_h [HLEN];
    logic        bd_h   [HLEN];
    logic        fd_h   [HLEN];

    int total = 0;
    int bad   = 0;
    int cnt, glitch, bd_hits, bd_total, fd_total, busy_gaps, tail_bad, base;
    logic [9:0] bits;
    logic       v;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic do_reset();
        reset_s = 1'b1;
        tick();
        tick();
        reset_s = 1'b0;
        tick();
    endtask

    initial begin
        bv[0] = '{3'd0, 3'd4, 5208};
        bv[1] = '{3'd1, 3'd0, 2604};
        bv[2] = '{3'd2, 3'd7, 1302};
        bv[3] = '{3'd3, 3'd4, 868};
        bv[4] = '{3'd4, 3'd0, 434};
        bv[5] = '{3'd5, 3'd4, 5208};
        bv[6] = '{3'd6, 3'd1, 5208};
        bv[7] = '{3'd7, 3'd3, 5208};

        exp_bytes[0] = 8'h55; exp_bytes[1] = 8'hA5; exp_bytes[2] = 8'h02;
        exp_bytes[3] = 8'hFA; exp_bytes[4] = 8'hF0; exp_bytes[5] = 8'h80;
        exp_bytes[6] = 8'h0F;
`ifdef UART_FRAME_TX_CHECKSUM_EN
        exp_bytes[7] = 8'h7B; exp_bytes[8] = 8'hF0;
`else
        exp_bytes[7] = 8'hF0; exp_bytes[8] = 8'h00;
`endif

        // ---- reset held 5 cycles, then 1000 idle cycles ----
        reset_s = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("reset_state", {tx_s, busy_s, bd_s, fd_s}, 4'b1000);
        reset_s = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if ({tx_s, busy_s, bd_s, fd_s} !== 4'b1000) cnt++;
        end
        check("idle_bad_cycles", cnt, 0);

        // ---- bit period per baud select, Baud_set changed after start ----
        for (int i = 0; i < 8; i++) begin
            do_reset();
            baud_s = bv[i].baud;
            ctrl_s = 8'h0F;
            time_s = 32'h02FA_F080;
            go_s   = 1'b1;
            tick();                       // n = 0
            go_s   = 1'b0;
            baud_s = bv[i].baud_after;
            tick();                       // n = 1
            check($sformatf("b%0d_n1_busy_tx", i), {busy_s, tx_s}, 2'b11);
            tick();                       // n = 2
            check($sformatf("b%0d_start_fall", i), tx_s, 1'b0);
            cnt = 0;
            while (tx_s === 1'b0 && cnt < bv[i].exp_cyc + 10) begin
                cnt++;
                tick();
            end
            check($sformatf("b%0d_start_len", i), cnt, bv[i].exp_cyc);
        end

        // ---- reset asserted during byte 3 start bit ----
        do_reset();
        baud_s = 3'd4;
        ctrl_s = 8'h3C;
        time_s = 32'hDEAD_BEEF;
        go_s   = 1'b1;
        tick();
        go_s   = 1'b0;
        for (int n = 1; n <= 2 + 3 * (10 * B4 + 1) + 75; n++) tick();
        check("rst_pre_tx_busy", {tx_s, busy_s}, 2'b01);
        reset_s = 1'b1;
        tick();
        check("rst_next_edge", {tx_s, busy_s, bd_s, fd_s}, 4'b1000);
        reset_s = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({tx_s, busy_s, bd_s, fd_s} !== 4'b1000) cnt++;
        end
        check("rst_after_quiet", cnt, 0);

        // ---- full frame; ignored Send_go with new inputs at n = 1000 ----
        baud_s = 3'd4;
        ctrl_s = 8'h0F;
        time_s = 32'h02FA_F080;
        go_s   = 1'b1;
        tick();
        go_s   = 1'b0;
        tx_h[0] = tx_s; busy_h[0] = busy_s; bd_h[0] = bd_s; fd_h[0] = fd_s;
        for (int n = 1; n <= FLEN + TAIL; n++) begin
            if (n == 1000) begin
                go_s   = 1'b1;
                ctrl_s = 8'hAA;
                time_s = 32'h1234_5678;
                baud_s = 3'd0;
            end else if (n == 1001) begin
                go_s   = 1'b0;
            end
            tick();
            tx_h[n] = tx_s; busy_h[n] = busy_s; bd_h[n] = bd_s; fd_h[n] = fd_s;
        end

        bd_hits = 0;
        for (int k = 0; k < NB; k++) begin
            base   = 2 + k * (10 * B4 + 1);
            glitch = 0;
            for (int j = 0; j < 10; j++) begin
                v = tx_h[base + j * B4];
                bits[j] = v;
                for (int c = 0; c < B4; c++)
                    if (tx_h[base + j * B4 + c] !== v) glitch++;
            end
            if (tx_h[base + 10 * B4] !== 1'b1) glitch++;
            check($sformatf("byte%0d_value", k), bits[8:1], exp_bytes[k]);
            check($sformatf("byte%0d_framing", k), {bits[9], bits[0]}, 2'b10);
            check($sformatf("byte%0d_bit_timing", k), glitch, 0);
            if (bd_h[base + 10 * B4] === 1'b1) bd_hits++;
        end

        bd_total = 0; fd_total = 0; busy_gaps = 0; tail_bad = 0;
        for (int n = 0; n <= FLEN + TAIL; n++) begin
            if (bd_h[n] === 1'b1) bd_total++;
            if (fd_h[n] === 1'b1) fd_total++;
            if (n >= 1 && n <= FLEN - 1 && busy_h[n] !== 1'b1) busy_gaps++;
            if (n >= FLEN && (busy_h[n] !== 1'b0 || tx_h[n] !== 1'b1)) tail_bad++;
        end
        check("frame_n1_busy_tx", {busy_h[1], tx_h[1]}, 2'b11);
        check("byte_done_positions", bd_hits, NB);
        check("byte_done_count", bd_total, NB);
        check("frame_done_count", fd_total, 1);
        check("frame_done_at_flen", {fd_h[FLEN], busy_h[FLEN], bd_h[FLEN]}, 3'b100);
        check("last_byte_done_before", {bd_h[FLEN-1], fd_h[FLEN-1], busy_h[FLEN-1]}, 3'b101);
        check("busy_gaps", busy_gaps, 0);
        check("no_second_frame", tail_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
